// File: rtl/add_arbiter_pkg.sv
// Shared definitions for the round-robin arbitrated adder: parameter defaults,
// slot-state encoding and the round-robin pointer advance rule.
package add_arbiter_pkg;

  localparam int NREQ_DEFAULT = 4;
  localparam int W_DEFAULT    = 32;
  localparam int CNT_W        = 16;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // Index of the requester that follows idx in a ring of n requesters.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/add_arbiter_rr_pick.sv
// Purely combinational round-robin picker: the first requester at or after
// ptr_i (wrapping at NREQ-1) wins, reported both one-hot and encoded.
module rr_pick #(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [NREQ-1:0]  gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  localparam logic [IDX_W:0] NREQ_W = (IDX_W + 1)'(NREQ);

  logic [IDX_W:0]   pos_v;
  logic [IDX_W-1:0] cand_v;

  // NOTE: every output and temporary gets a default before the loop; without
  // it the "no requester" path would leave them unassigned and infer latches.
  always_comb begin
    gnt_o  = '0;
    idx_o  = '0;
    any_o  = 1'b0;
    pos_v  = '0;
    cand_v = '0;
    for (int k = 0; k < NREQ; k++) begin
      // ptr_i < NREQ and k < NREQ, so one conditional subtract is a full modulo.
      pos_v = {1'b0, ptr_i} + (IDX_W + 1)'(k);
      if (pos_v >= NREQ_W) begin
        pos_v = pos_v - NREQ_W;
      end
      cand_v = pos_v[IDX_W-1:0];
      if (!any_o && req_i[cand_v]) begin
        any_o         = 1'b1;
        idx_o         = cand_v;
        gnt_o[cand_v] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/add_arbiter.sv
// NREQ requesters share one W-bit adder through a round-robin arbiter feeding
// a single-entry output register with valid/ready handshake.
module add_arbiter
  import add_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT,
  parameter int W    = W_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*W-1:0]        req_a,
  input  logic [NREQ*W-1:0]        req_b,
  output logic [NREQ-1:0]          req_ready,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [$clog2(NREQ)-1:0]  resp_id,
  output logic [W-1:0]             resp_sum,
  output logic                     resp_carry,
  output logic [CNT_W-1:0]         txn_count
);

  localparam int IDX_W = $clog2(NREQ);

  slot_state_e      state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] id_q, id_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [NREQ-1:0]  gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_any;
  logic             grant_en;
  logic             accept;
  logic [W-1:0]     op_a, op_b;
  logic [W:0]       add_full;

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  // The slot can take a new result when empty or when it drains this cycle.
  assign grant_en  = (state_q == SLOT_EMPTY) || resp_ready;
  assign accept    = grant_en && gnt_any;
  assign req_ready = (rst_n && grant_en) ? gnt : '0;

  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      op_a = op_a | (req_a[i*W +: W] & {W{gnt[i]}});
      op_b = op_b | (req_b[i*W +: W] & {W{gnt[i]}});
    end
  end

  assign add_full = {1'b0, op_a} + {1'b0, op_b};

  // Slot FSM: state register.
  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples values from before the edge, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SLOT_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Slot FSM: next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SLOT_EMPTY: if (accept) state_d = SLOT_FULL;
      SLOT_FULL:  if (resp_ready && !accept) state_d = SLOT_EMPTY;
      default:    state_d = SLOT_EMPTY;
    endcase
  end

  // Slot FSM: outputs.
  always_comb begin
    resp_valid = (state_q == SLOT_FULL);
  end

  always_comb begin
    ptr_d   = ptr_q;
    id_d    = id_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    if (accept) begin
      ptr_d   = IDX_W'(rr_next(int'(gnt_idx), NREQ));
      id_d    = gnt_idx;
      sum_d   = add_full[W-1:0];
      carry_d = add_full[W];
      cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: the result register is reset too, because resp_id/sum/carry must
  // read zero after reset rather than stale data from before it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      id_q    <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  assign resp_id    = id_q;
  assign resp_sum   = sum_q;
  assign resp_carry = carry_q;
  assign txn_count  = cnt_q;

  a_ready_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(req_ready));
  a_ready_only_valid : assert property (@(posedge clk) disable iff (!rst_n)
    ((req_ready & ~req_valid) == '0));
  a_hold_on_stall : assert property (@(posedge clk) disable iff (!rst_n)
    (resp_valid && !resp_ready) |=> (resp_valid && $stable(resp_id)
                                     && $stable(resp_sum) && $stable(resp_carry)));

endmodule

// File: tb/tb_add_arbiter.sv
// Self-checking bench for add_arbiter: directed scenarios plus random traffic
// checked against a transaction-level model of arbitration and the result slot.
module tb_add_arbiter;

  localparam int NREQ  = 4;
  localparam int W     = 32;
  localparam int IDX_W = $clog2(NREQ);

  logic                clk;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*W-1:0]   req_a;
  logic [NREQ*W-1:0]   req_b;
  logic [NREQ-1:0]     req_ready;
  logic                resp_valid;
  logic                resp_ready;
  logic [IDX_W-1:0]    resp_id;
  logic [W-1:0]        resp_sum;
  logic                resp_carry;
  logic [15:0]         txn_count;

  add_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_sum   (resp_sum),
    .resp_carry (resp_carry),
    .txn_count  (txn_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Requester-side view: pending flag and operands per requester.
  logic         pend [NREQ];
  logic [W-1:0] op_a [NREQ];
  logic [W-1:0] op_b [NREQ];

  // Model of the result slot, arbitration pointer and accept counter.
  logic         m_valid;
  int           m_id;
  logic [W-1:0] m_sum;
  logic         m_carry;
  int           m_ptr;
  int           m_cnt;

  function automatic int model_pick();
    if (m_valid && !resp_ready) return -1;
    for (int k = 0; k < NREQ; k++) begin
      int idx = (m_ptr + k) % NREQ;
      if (pend[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_id = 0; m_sum = '0; m_carry = 1'b0; m_ptr = 0; m_cnt = 0;
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]       = pend[i];
      req_a[i*W +: W]    = op_a[i];
      req_b[i*W +: W]    = op_b[i];
    end
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    pend[i] = 1'b1; op_a[i] = a; op_b[i] = b;
  endtask

  // One clock cycle: entered just after a rising edge, returns just after the next.
  task automatic run_cycle(input string tag);
    int              g;
    logic [NREQ-1:0] exp_rdy;
    logic [W:0]      full;
    logic [IDX_W-1:0] exp_id;
    drive_inputs();
    #1;
    g = model_pick();
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    compared++;
    if (req_ready !== exp_rdy) begin
      mismatched++;
      $display("FAIL %s req_ready: got %b want %b", tag, req_ready, exp_rdy);
    end
    @(posedge clk);
    if (g >= 0) begin
      full    = {1'b0, op_a[g]} + {1'b0, op_b[g]};
      m_valid = 1'b1;
      m_id    = g;
      m_sum   = full[W-1:0];
      m_carry = full[W];
      m_cnt   = (m_cnt + 1) % 65536;
      m_ptr   = (g + 1) % NREQ;
      pend[g] = 1'b0;
    end else if (m_valid && resp_ready) begin
      m_valid = 1'b0;
    end
    #1;
    exp_id = IDX_W'(m_id);
    compared++;
    if (resp_valid !== m_valid || txn_count !== 16'(m_cnt)) begin
      mismatched++;
      $display("FAIL %s valid/count: got %b/%h want %b/%h", tag, resp_valid, txn_count,
               m_valid, 16'(m_cnt));
    end
    if (m_valid) begin
      compared++;
      if (resp_id !== exp_id || resp_sum !== m_sum || resp_carry !== m_carry) begin
        mismatched++;
        $display("FAIL %s result: got id=%0d sum=%h c=%b want id=%0d sum=%h c=%b", tag,
                 resp_id, resp_sum, resp_carry, exp_id, m_sum, m_carry);
      end
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    drive_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    set_req(0, 32'h1, 32'h1);
    resp_ready = 1'b1;
    drive_inputs();
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if (resp_valid !== 1'b0 || resp_id !== '0 || resp_sum !== '0 || resp_carry !== 1'b0
        || txn_count !== 16'h0 || req_ready !== '0) begin
      mismatched++;
      $display("FAIL reset_state: got v=%b id=%0d sum=%h c=%b cnt=%h rdy=%b want all zero",
               resp_valid, resp_id, resp_sum, resp_carry, txn_count, req_ready);
    end
    pend[0] = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    apply_reset();
    resp_ready = 1'b1;
    set_req(0, 32'h0000_0005, 32'h0000_0003);
    run_cycle("basic");
    compared++;
    if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_sum !== 32'h8 || resp_carry !== 1'b0
        || txn_count !== 16'd1) begin
      mismatched++;
      $display("FAIL basic_add: got v=%b id=%0d sum=%h c=%b cnt=%0d want 1/0/00000008/0/1",
               resp_valid, resp_id, resp_sum, resp_carry, txn_count);
    end
  endtask

  task automatic test_overflow();
    resp_ready = 1'b1;
    set_req(0, 32'hFFFF_FFFF, 32'h0000_0002);
    run_cycle("overflow");
    compared++;
    if (resp_sum !== 32'h1 || resp_carry !== 1'b1) begin
      mismatched++;
      $display("FAIL overflow: got sum=%h c=%b want 00000001/1", resp_sum, resp_carry);
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    resp_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < NREQ; i++) if (!pend[i]) set_req(i, $urandom, $urandom);
      run_cycle("round_robin");
      compared++;
      if (resp_valid !== 1'b1 || resp_id !== IDX_W'(c % NREQ)) begin
        mismatched++;
        $display("FAIL rr_order cycle %0d: got v=%b id=%0d want 1/%0d", c, resp_valid,
                 resp_id, c % NREQ);
      end
    end
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    run_cycle("rr_drain");
  endtask

  task automatic test_back_to_back_stall();
    logic [W-1:0]     snap_sum;
    logic [IDX_W-1:0] snap_id;
    logic             snap_c;
    resp_ready = 1'b1;
    set_req(0, 32'h1234_0000, 32'h0000_5678);
    run_cycle("stall_fill");
    snap_sum = resp_sum; snap_id = resp_id; snap_c = resp_carry;
    set_req(1, 32'hA000_0000, 32'h7000_0001);
    resp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      run_cycle("stall_hold");
      compared++;
      if (req_ready !== '0 || resp_valid !== 1'b1 || resp_sum !== snap_sum
          || resp_id !== snap_id || resp_carry !== snap_c) begin
        mismatched++;
        $display("FAIL stall_stable cycle %0d: got rdy=%b v=%b id=%0d sum=%h want 0000/1/%0d/%h",
                 c, req_ready, resp_valid, resp_id, resp_sum, snap_id, snap_sum);
      end
    end
    resp_ready = 1'b1;
    drive_inputs();
    #1;
    compared++;
    if (req_ready !== 4'b0010) begin
      mismatched++;
      $display("FAIL stall_release_grant: got %b want 0010", req_ready);
    end
    run_cycle("stall_release");
    compared++;
    if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_sum !== 32'h1000_0001
        || resp_carry !== 1'b1) begin
      mismatched++;
      $display("FAIL stall_next_result: got v=%b id=%0d sum=%h c=%b want 1/1/10000001/1",
               resp_valid, resp_id, resp_sum, resp_carry);
    end
  endtask

  task automatic test_reset_mid();
    resp_ready = 1'b0;
    set_req(0, 32'h10, 32'h20);
    run_cycle("midrst_pre");
    set_req(0, 32'h10, 32'h20);
    set_req(2, 32'h30, 32'h40);
    resp_ready = 1'b0;
    drive_inputs();
    #3;
    rst_n = 1'b0;
    #1;
    compared++;
    if (resp_valid !== 1'b0 || txn_count !== 16'h0 || req_ready !== '0) begin
      mismatched++;
      $display("FAIL midrst_clear: got v=%b cnt=%h rdy=%b want 0/0000/0000",
               resp_valid, txn_count, req_ready);
    end
    model_reset();
    set_req(0, 32'h10, 32'h20);
    set_req(2, 32'h30, 32'h40);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    resp_ready = 1'b1;
    drive_inputs();
    #1;
    compared++;
    if (req_ready !== 4'b0001) begin
      mismatched++;
      $display("FAIL midrst_first_grant: got %b want 0001", req_ready);
    end
    run_cycle("midrst_after");
    run_cycle("midrst_after2");
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && ($urandom_range(1, 0) == 1)) set_req(i, $urandom, $urandom);
      end
      resp_ready = ($urandom_range(3, 0) != 0);
      run_cycle("random");
    end
  endtask

  task automatic test_count_wrap();
    apply_reset();
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = 32'h1; op_b[i] = 32'h1;
    end
    req_valid  = '1;
    resp_ready = 1'b1;
    repeat (65535) @(posedge clk);
    #1;
    compared++;
    if (txn_count !== 16'hFFFF) begin
      mismatched++;
      $display("FAIL count_preload: got %h want ffff", txn_count);
    end
    @(posedge clk);
    #1;
    compared++;
    if (txn_count !== 16'h0000) begin
      mismatched++;
      $display("FAIL count_wrap: got %h want 0000", txn_count);
    end
    req_valid = '0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = '0; op_b[i] = '0;
    end
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b0;
    rst_n      = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_overflow();
    test_round_robin();
    test_back_to_back_stall();
    test_reset_mid();
    test_random();
    test_count_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
